alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- sequential ALU with a valid/ready request and result handshake.
//
// Single-cycle operations (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, illegal)
// finish on the accepting edge. MUL is an unsigned shift-add multiplier that
// consumes one multiplier bit per cycle, so it reaches DONE WIDTH edges after
// it is accepted. Result and flags are held in DONE until the consumer takes
// them.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid / in_ready         request handshake (in_ready only in IDLE)
//   op_code, op_a, op_b         operation select and operands
//   out_valid / out_ready       result handshake (out_valid only in DONE)
//   result                      WIDTH-bit result
//   flag_carry, flag_overflow,
//   flag_parity, flag_neg,
//   flag_zero                   status flags registered with the result
//   busy                        high in MUL and DONE
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_carry,
    output logic             flag_overflow,
    output logic             flag_parity,
    output logic             flag_neg,
    output logic             flag_zero,
    output logic             busy
);

    localparam int SW = $clog2(WIDTH);
    // One extra bit keeps the counter at least 4 bits wide for WIDTH = 8.
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic parity_f(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    state_t           state_q, state_d;
    logic             init_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
    logic [WIDTH-1:0] result_q;
    logic             carry_q, ovf_q, par_q, neg_q, zero_q;

    logic             in_ready_s, out_valid_s, busy_s, accept_s;
    logic [SW-1:0]    sh_s;
    logic [WIDTH:0]   sum_s, diff_s, shl_s, shr_s, sra_s;
    logic [WIDTH-1:0] alu_res_s, acc_nxt_s, ld_res_s;
    logic             alu_c_s, alu_v_s, ld_en_s, ld_c_s, ld_v_s;

    assign accept_s  = in_valid & in_ready_s;
    assign sh_s      = op_b[SW-1:0];
    // Extended operands: the extra bit catches carry/borrow or the last bit
    // shifted out (which is 0 for a zero shift amount).
    assign sum_s     = {1'b0, op_a} + {1'b0, op_b};
    assign diff_s    = {1'b0, op_a} - {1'b0, op_b};
    assign shl_s     = {1'b0, op_a} << sh_s;
    assign shr_s     = {op_a, 1'b0} >> sh_s;
    assign sra_s     = $signed({op_a, 1'b0}) >>> sh_s;
    assign acc_nxt_s = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});

    // Single-cycle ALU result and carry/overflow from the live inputs.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
        case (op_code)
            OP_ADD: begin
                alu_res_s = sum_s[WIDTH-1:0];
                alu_c_s   = sum_s[WIDTH];
                alu_v_s   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                            (sum_s[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res_s = diff_s[WIDTH-1:0];
                alu_c_s   = diff_s[WIDTH];
                alu_v_s   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                            (diff_s[WIDTH-1] != op_a[WIDTH-1]);
            end
            OP_AND: alu_res_s = op_a & op_b;
            OP_OR:  alu_res_s = op_a | op_b;
            OP_XOR: alu_res_s = op_a ^ op_b;
            OP_SLL: begin
                alu_res_s = shl_s[WIDTH-1:0];
                alu_c_s   = shl_s[WIDTH];
            end
            OP_SRL: begin
                alu_res_s = shr_s[WIDTH:1];
                alu_c_s   = shr_s[0];
            end
            OP_SRA: begin
                alu_res_s = sra_s[WIDTH:1];
                alu_c_s   = sra_s[0];
            end
            default: alu_res_s = {WIDTH{1'b0}};  // MUL handled iteratively; illegal -> 0
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = (op_code == OP_MUL) ? S_MUL : S_DONE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State-decoded handshake outputs; in_ready waits for the first edge after reset.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_q)
            S_IDLE: in_ready_s = init_q;
            S_MUL:  busy_s     = 1'b1;
            S_DONE: begin
                out_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: busy_s = 1'b0;
        endcase
    end

    // Selects what gets written into the result/flag registers this edge.
    always_comb begin
        ld_en_s  = 1'b0;
        ld_res_s = alu_res_s;
        ld_c_s   = alu_c_s;
        ld_v_s   = alu_v_s;
        if (accept_s && (op_code != OP_MUL)) begin
            ld_en_s = 1'b1;
        end else if ((state_q == S_MUL) && (cnt_q == CNT_LAST)) begin
            ld_en_s  = 1'b1;
            ld_res_s = acc_nxt_s;
            ld_c_s   = 1'b0;
            ld_v_s   = 1'b0;
        end else begin
            ld_en_s = 1'b0;
        end
    end

    // Out-of-reset marker, multiplier datapath, and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q   <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            par_q    <= 1'b0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            init_q <= 1'b1;
            if (accept_s && (op_code == OP_MUL)) begin
                cnt_q    <= {CW{1'b0}};
                mcand_q  <= op_a;
                mplier_q <= op_b;
                acc_q    <= {WIDTH{1'b0}};
            end else if (state_q == S_MUL) begin
                cnt_q    <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                acc_q    <= acc_nxt_s;
            end
            if (ld_en_s) begin
                result_q <= ld_res_s;
                carry_q  <= ld_c_s;
                ovf_q    <= ld_v_s;
                par_q    <= parity_f(ld_res_s);
                neg_q    <= ld_res_s[WIDTH-1];
                zero_q   <= (ld_res_s == {WIDTH{1'b0}});
            end
        end
    end

    assign in_ready      = in_ready_s;
    assign out_valid     = out_valid_s;
    assign busy          = busy_s;
    assign result        = result_q;
    assign flag_carry    = carry_q;
    assign flag_overflow = ovf_q;
    assign flag_parity   = par_q;
    assign flag_neg      = neg_q;
    assign flag_zero     = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH = 32).
// Directed table of vectors, random operations against a behavioural model,
// and hand-written sequences for DONE hold and reset during MUL.
// Flag vectors are packed {carry, overflow, parity, neg, zero}.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op_code = 4'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         in_ready, out_valid, busy;
    logic [W-1:0] result;
    logic         flag_carry, flag_overflow, flag_parity, flag_neg, flag_zero;

    int n_vec = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_carry(flag_carry), .flag_overflow(flag_overflow),
        .flag_parity(flag_parity), .flag_neg(flag_neg), .flag_zero(flag_zero),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [4:0]   f;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic logic [4:0] flags_now();
        return {flag_carry, flag_overflow, flag_parity, flag_neg, flag_zero};
    endfunction

    // Behavioural reference computed with 64-bit integer arithmetic.
    function automatic void model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [4:0] f);
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint unsigned t;
        longint sa = longint'(signed'(a));
        longint sb = longint'(signed'(b));
        longint st;
        int sh = int'(b[4:0]);
        logic c = 1'b0;
        logic v = 1'b0;
        case (op)
            4'd0: begin
                t = ua + ub; r = t[31:0]; c = t[32];
                st = sa + sb; v = (st != longint'(signed'(r)));
            end
            4'd1: begin
                r = a - b; c = (ua < ub);
                st = sa - sb; v = (st != longint'(signed'(r)));
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: begin
                t = ua << sh; r = t[31:0];
                c = (sh != 0) ? t[32] : 1'b0;
            end
            4'd6: begin
                r = a >> sh;
                c = (sh != 0) ? a[sh-1] : 1'b0;
            end
            4'd7: begin
                st = sa >>> sh; r = st[31:0];
                c = (sh != 0) ? a[sh-1] : 1'b0;
            end
            4'd8: begin
                t = ua * ub; r = t[31:0];
            end
            default: r = '0;
        endcase
        f = {c, v, ($countones(r) % 2 == 1), r[W-1], (r == '0)};
    endfunction

    // Presents a request and returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; op_code = op; op_a = a; op_b = b;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_code  = 4'($urandom_range(0, 15));
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    // Counts edges after the accept until out_valid; checks in_ready/busy meanwhile.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (in_ready || !busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_after_take", 64'(out_valid), 64'd0);
    endtask

    task automatic run_check(input string name, input logic [3:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [W-1:0] er, input logic [4:0] ef);
        int lat;
        bit busy_ok;
        issue(op, a, b);
        wait_done(lat, busy_ok);
        chk({name, "_out_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_result"}, 64'(result), 64'(er));
        chk({name, "_flags"}, 64'(flags_now()), 64'(ef));
        chk({name, "_latency"}, 64'(lat), (op == 4'd8) ? 64'(W) : 64'd0);
        if (op == 4'd8) chk({name, "_busy_in_mul"}, 64'(busy_ok), 64'd1);
        release_result();
    endtask

    logic [W-1:0] er, ra, rb;
    logic [3:0]   rop;
    logic [4:0]   ef;
    int           lat;
    bit           bok, seen;

    initial begin
        tbl[0] = '{4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 5'b10001};
        tbl[1] = '{4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 5'b01100};
        tbl[2] = '{4'd7,  32'h80000001, 32'h00000021, 32'hC0000000, 5'b10010};
        tbl[3] = '{4'd5,  32'h12345678, 32'h00000000, 32'h12345678, 5'b00100};
        tbl[4] = '{4'd12, 32'hDEADBEEF, 32'h00001234, 32'h00000000, 5'b00001};
        tbl[5] = '{4'd8,  32'h00010001, 32'h00010001, 32'h00020001, 5'b00000};
        tbl[6] = '{4'd6,  32'h00000003, 32'h00000001, 32'h00000001, 5'b10100};
        tbl[7] = '{4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 5'b00010};
        tbl[8] = '{4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 5'b01110};
        tbl[9] = '{4'd5,  32'h80000000, 32'h00000001, 32'h00000000, 5'b10001};

        // Reset state.
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_flags", 64'(flags_now()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("in_ready_after_edge", 64'(in_ready), 64'd1);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].f);
        end

        // Random operations against the model.
        for (int i = 0; i < 150; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) ra = (i % 2 == 0) ? 32'h80000000 : 32'hFFFFFFFF;
            if ($urandom_range(0, 5) == 0) rb = 32'($urandom_range(0, 2));
            model(rop, ra, rb, er, ef);
            run_check($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb, er, ef);
        end

        // MUL with the result held for 5 cycles while a new request is pending.
        issue(4'd8, 32'h00010001, 32'h00010001);
        wait_done(lat, bok);
        chk("hold_latency", 64'(lat), 64'(W));
        chk("hold_busy_in_mul", 64'(bok), 64'd1);
        @(negedge clk);
        in_valid = 1'b1; op_code = 4'd0; op_a = 32'd10; op_b = 32'd20;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("hold_result", 64'(result), 64'h00020001);
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        // Handshake edge with in_valid still high: the ADD must wait one more edge.
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("no_accept_on_take_valid", 64'(out_valid), 64'd0);
        chk("no_accept_on_take_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pending_add_valid", 64'(out_valid), 64'd1);
        chk("pending_add_result", 64'(result), 64'd30);
        release_result();

        // Reset in the middle of a MUL.
        issue(4'd8, 32'h00012345, 32'h00000777);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_flags", 64'(flags_now()), 64'd0);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_out_valid", 64'(seen), 64'd0);
        run_check("post_abort_add", 4'd0, 32'd3, 32'd4, 32'd7, 5'b00100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
